// File: rtl/echo_pkg.sv
// Shared types and constants for the echo canceller: FSM state encoding,
// gain fraction width and the output saturation limits.
package echo_pkg;

  typedef enum logic [1:0] {IDLE, RD, MUL, SUB} state_t;

  localparam int GAIN_FRAC_BITS  = 6;
  localparam int ECHO_DATA_WIDTH = 16;

  localparam logic signed [ECHO_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(ECHO_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ECHO_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(ECHO_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/echo_cancel_ram.sv
// Simple dual-port sample history RAM: one write port, one registered read
// port, no reset, shaped so it maps onto a Gowin BSRAM block.
module echo_cancel_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 12
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/echo_cancel.sv
// Single-tap echo remover: y[n] = x[n] - (g/64)*x[n-D], one sample per strobe.
// Define ECHO_CANCEL_SAT_EN to clamp the output instead of wrapping it.
//
// state | meaning
// IDLE  | waiting for sample_valid; accept writes RAM and issues the delayed read
// RD    | delayed sample available from the RAM read register
// MUL   | product g * x[n-D] registered
// SUB   | difference formed, sample_out / out_valid updated
module echo_cancel
  import echo_pkg::*;
#(
  parameter int DATA_WIDTH = ECHO_DATA_WIDTH,
  parameter int DELAY_AW   = 12,
  parameter int GAIN_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic [DELAY_AW-1:0]   delay_num,
  input  logic [GAIN_W-1:0]     gain,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  overrun
);

  localparam int PW = DATA_WIDTH + GAIN_W + 1;

  state_t state, state_nx;

  logic                         accept;
  logic [DELAY_AW-1:0]          wr_ptr, fill_cnt, rd_addr;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic signed [DATA_WIDTH-1:0] x_r, xd;
  logic [GAIN_W-1:0]            g_r;
  logic                         zero_d;
  logic signed [PW-1:0]         g_ext, xd_ext, p_r;
  logic signed [PW-GAIN_FRAC_BITS-1:0] e;
  logic signed [DATA_WIDTH:0]   d;
  logic [DATA_WIDTH-1:0]        d_out;
  logic                         unused_frac;

  assign accept  = (state == IDLE) && sample_valid;
  assign rd_addr = wr_ptr - delay_num;

  echo_cancel_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_W    (DELAY_AW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (accept),
    .wr_addr(wr_ptr),
    .wr_data(sample_in),
    .rd_en  (accept),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sample_valid) state_nx = RD;
      RD:      state_nx = MUL;
      MUL:     state_nx = SUB;
      SUB:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Uninitialised or not-yet-written history reads as zero via zero_d.
  assign xd     = zero_d ? '0 : $signed(rd_data);
  assign g_ext  = $signed({{(PW-GAIN_W){1'b0}}, g_r});
  assign xd_ext = {{(PW-DATA_WIDTH){xd[DATA_WIDTH-1]}}, xd};

  // Dropping the fraction bits is the arithmetic shift (floor) by 6.
  assign e           = p_r[PW-1:GAIN_FRAC_BITS];
  assign unused_frac = ^p_r[GAIN_FRAC_BITS-1:0];
  assign d           = {x_r[DATA_WIDTH-1], x_r} - e;

`ifdef ECHO_CANCEL_SAT_EN
  always_comb begin
    d_out = d[DATA_WIDTH-1:0];
    if (d[DATA_WIDTH] != d[DATA_WIDTH-1])
      d_out = d[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
  end
`else
  assign d_out = d[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      x_r        <= '0;
      g_r        <= '0;
      zero_d     <= 1'b1;
      p_r        <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample_valid && (state != IDLE);
      if (accept) begin
        x_r    <= sample_in;
        g_r    <= gain;
        zero_d <= (delay_num == '0) || (fill_cnt < delay_num);
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
      end
      if (state == MUL) p_r <= g_ext * xd_ext;
      if (state == SUB) begin
        sample_out <= d_out;
        out_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_echo_cancel.sv
// Self-checking bench for echo_cancel: directed cases plus random streams
// compared against an arithmetic model of y[n] = x[n] - floor(g*x[n-D]/64).
module tb_echo_cancel;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic [11:0] delay_num;
  logic [5:0]  gain;
  logic        busy;
  logic        out_valid;
  logic [15:0] sample_out;
  logic        overrun;

  int n_total = 0;
  int n_bad   = 0;
  int hist[$];
  int fill = 0;

  always #5 clk = ~clk;

  echo_cancel dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .delay_num   (delay_num),
    .gain        (gain),
    .busy        (busy),
    .out_valid   (out_valid),
    .sample_out  (sample_out),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int out_now();
    logic signed [15:0] s;
    s = sample_out;
    return int'(s);
  endfunction

  // Reference: history of accepted inputs since reset, saturating fill count.
  function automatic int model_step(input int x, input int d, input int g);
    int xd, prod, e, y;
    logic signed [15:0] w;
    if (d == 0 || fill < d) xd = 0;
    else xd = hist[hist.size() - d];
    prod = g * xd;
    if (prod >= 0) e = prod / 64;
    else e = -((-prod + 63) / 64);
    y = x - e;
`ifdef ECHO_CANCEL_SAT_EN
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
`else
    w = y[15:0];
    y = int'(w);
`endif
    hist.push_back(x);
    if (hist.size() > 4096) void'(hist.pop_front());
    if (fill < 4095) fill++;
    return y;
  endfunction

  task automatic model_reset();
    hist.delete();
    fill = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen.
  task automatic send(input string tag, input int x, input int d, input int g, input int gap);
    int exp, lat;
    bit seen;
    exp = model_step(x, d, g);
    sample_valid = 1'b1;
    sample_in    = x[15:0];
    delay_num    = d[11:0];
    gain         = g[5:0];
    @(negedge clk);
    sample_valid = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_valid_seen"}, int'(seen), 1);
    chk({tag, "_latency"}, lat, 3);
    chk(tag, out_now(), exp);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int echo_x[13] = '{1000, 0, 0, 0, 500, 0, 0, 0, 250, 0, 0, 0, 125};
    int fill_x[4]  = '{100, 200, 300, 400};
    int ov, ovl, at, y, exp0;

    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    delay_num    = '0;
    gain         = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_sample_out", out_now(), 0);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);

    foreach (echo_x[i]) send("echo", echo_x[i], 4, 32, 4);

    do_reset();
    foreach (fill_x[i]) send("fill_gate", fill_x[i], 3, 63, 0);

    do_reset();
    send("sat_a", -32768, 1, 63, 0);
    send("sat_b", 32767, 1, 63, 0);

    do_reset();
    send("neg_floor_a", -1, 1, 1, 0);
    send("neg_floor_b", 0, 1, 1, 0);

    // Overrun: second strobe lands while the FSM is in MUL.
    do_reset();
    exp0 = model_step(640, 1, 32);
    sample_valid = 1'b1;
    sample_in    = 16'd640;
    delay_num    = 12'd1;
    gain         = 6'd32;
    ov = 0; ovl = 0; at = -1; y = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (overrun) ov++;
      if (out_valid) begin
        ovl++;
        at = i;
        y  = out_now();
      end
      if (i == 1) sample_valid = 1'b0;
      if (i == 2) begin
        sample_valid = 1'b1;
        sample_in    = 16'd2000;
      end
      if (i == 3) sample_valid = 1'b0;
    end
    chk("overrun_pulses", ov, 1);
    chk("overrun_out_valids", ovl, 1);
    chk("overrun_out_at", at, 4);
    chk("overrun_out_value", y, exp0);
    send("overrun_ptr", 0, 1, 32, 0);

    // Reset pulled while the sample is in MUL.
    do_reset();
    sample_valid = 1'b1;
    sample_in    = 16'd1234;
    delay_num    = 12'd2;
    gain         = 6'd63;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    ovl = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || busy) ovl++;
    end
    chk("midrst_quiet", ovl, 0);
    chk("midrst_sample_out", out_now(), 0);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    send("post_rst_a", 555, 2, 63, 0);
    send("post_rst_b", -7, 2, 63, 0);
    send("post_rst_c", 100, 2, 63, 0);

    // Random stream with changing delay/gain and variable spacing.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int x, d, g, gap;
      x   = int'($urandom_range(65535)) - 32768;
      d   = int'($urandom_range(12));
      g   = int'($urandom_range(63));
      gap = int'($urandom_range(3));
      send("random", x, d, g, gap);
    end

    // Long delay across the write-pointer wrap.
    do_reset();
    for (int i = 0; i < 4100; i++) begin
      int x;
      x = int'($urandom_range(65535)) - 32768;
      send("wrap", x, 4000, 32, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/echo_cancel.md
# echo_cancel

Inverse of the echo effect path: it removes a single-tap feedback echo from a 16-bit signed audio stream. It computes y[n] = x[n] − (g/64)·x[n−D]. This is the FIR inverse of the comb that the echo path applies, x[n] = s[n] + (g/64)·x[n−D]. The block sits between the I2S receive deserializer and downstream processing, runs on the system clock, and handles one sample per strobe. Past inputs are held in an internal circular buffer.

## Interface
- DATA_WIDTH, 16, sample width, signed two's complement
- DELAY_AW, 12, buffer address width; depth = 2^DELAY_AW samples
- GAIN_W, 6, gain width; gain is unsigned Q0.6, value g/64
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- sample_valid  in  1  one-cycle strobe, sample_in valid
- sample_in  in  DATA_WIDTH  echoed input sample x[n]
- delay_num  in  DELAY_AW  echo delay D in samples; sampled on accept
- gain  in  GAIN_W  echo gain g; sampled on accept
- busy  out  1  high while a sample is in flight
- out_valid  out  1  one-cycle strobe, sample_out valid
- sample_out  out  DATA_WIDTH  de-echoed sample y[n]
- overrun  out  1  one-cycle pulse when sample_valid arrives while busy

## Operation
- FSM states: IDLE → RD → MUL → SUB → IDLE, one cycle each. Only IDLE accepts input.
- **IDLE accept** (sample_valid=1):
  - latch x, D and g
  - write x to buf[wr_ptr]
  - issue a read at (wr_ptr − D) mod 2^DELAY_AW
  - increment wr_ptr, which wraps naturally
  - increment fill_cnt, which saturates at 2^DELAY_AW − 1
  - go to RD
- **RD:** registered RAM read data (xd) becomes available.
- **MUL:** compute p = g × xd, signed, DATA_WIDTH+GAIN_W+1 bits, and register it.
- **SUB:**
  - e = p >>> 6 (arithmetic shift, floor)
  - d = x − e, computed at DATA_WIDTH+1 bits
  - sample_out ← d, saturated or wrapped per Configuration
  - pulse out_valid
- **Delayed-term zeroing:** xd is forced to 0 if D = 0, or if fill_cnt (before this accept) < D. This covers uninitialised RAM after reset.
- **sample_valid in RD/MUL/SUB:** the sample is dropped. overrun pulses the next cycle; nothing else changes.
- **Changes to delay_num or gain** between samples take effect on the next accept. fill_cnt is not cleared.
- **Reset values:**
  - state = IDLE
  - wr_ptr = 0, fill_cnt = 0
  - busy = 0, out_valid = 0, overrun = 0
  - sample_out = 0
  - RAM contents are not cleared.
- **Reset asserted mid-operation:** the in-flight sample is discarded and out_valid does not pulse.

## Timing
- Accept at edge E0. busy is high after E0 through E3. out_valid and sample_out update at E3, so latency is 3 cycles.
- The earliest next accept is E4, giving a minimum strobe spacing of 4 clk cycles.
- sample_out holds its value until the next out_valid.
- The RAM has a synchronous read with 1-cycle latency. Read and write addresses never collide, because D = 0 is bypassed.

## Configuration
- ECHO_CANCEL_SAT_EN
  - **Defined:** d is clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - **Undefined:** d is truncated to its low DATA_WIDTH bits (two's-complement wrap).

## Structure
- **Package echo_pkg** holds:
  - the FSM state enum (IDLE, RD, MUL, SUB)
  - GAIN_FRAC_BITS = 6
  - the saturation limit constants derived from DATA_WIDTH
- **Sub-module echo_cancel_ram:** simple dual-port RAM, DATA_WIDTH × 2^DELAY_AW, with one write port and one registered read port. Its interface is kept inference-friendly for Gowin BSRAM.

## Test plan
- **Echo removal:** D=4, g=32. Feed x = 1000,0,0,0,500,0,0,0,250,0,0,0,125 at spacing 8. Required output: 1000 followed by twelve 0s.
- **Fill-count gating:** immediately after reset, D=3, g=63. Feed x = 100,200,300,400. Required output: 100,200,300,302. The last value is 400 − (63·100>>>6 = 98).
- **Saturation:** D=1, g=63. Feed x = −32768, 32767.
  - With ECHO_CANCEL_SAT_EN: second output = 32767.
  - Without it: second output = −513 (raw d = 32767 + 32256 = 65023).
- **Negative floor:** D=1, g=1. Feed x = −1, 0. Second output = 1, since (−1·1)>>>6 = −1.
- **Overrun:** assert sample_valid at E0 and E2.
  - overrun pulses once.
  - Only one out_valid appears, at E3.
  - wr_ptr advances by 1.
- **Wrap and reset:**
  - Feed 4100 samples with D=4000, g=32. Outputs must stay correct across the wr_ptr wrap.
  - Pull reset_n low during MUL: out_valid stays 0, busy = 0 next cycle, and the first output after release follows the fill-count gating.
